song_sequencer: RTL and testbench

Playback controller for the music-player datapath. It steps through a note ROM holding one song per quarter of the address space. For each entry it fetches pitch and duration, holds the pitch for the duration's worth of beat ticks, then inserts a silent gap. It detects end of song (zero-duration marker or index wrap), handles play/pause, and pulses done for the downstream end-of-song logic.

---
 rtl/song_sequencer_if.sv | 30 +++
 rtl/song_sequencer.sv | 155 +++++++++++++++
 tb/tb_song_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/song_sequencer_if.sv
// Playback control / ROM bus bundle for song_sequencer.
// master: the side that drives controls and returns ROM data (player top, bench).
// slave : the sequencer itself.
interface song_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int PITCH_W = 5,
    parameter int DUR_W   = 6
);
    logic               beat_tick;
    logic               play;
    logic               pause;
    logic [1:0]         song_sel;
    logic [ADDR_W-1:0]  rom_addr;
    logic [PITCH_W-1:0] rom_pitch;
    logic [DUR_W-1:0]   rom_dur;
    logic [PITCH_W-1:0] note_pitch;
    logic               note_valid;
    logic               busy;
    logic               done;

    modport master (
        output beat_tick, play, pause, song_sel, rom_pitch, rom_dur,
        input  rom_addr, note_pitch, note_valid, busy, done
    );

    modport slave (
        input  beat_tick, play, pause, song_sel, rom_pitch, rom_dur,
        output rom_addr, note_pitch, note_valid, busy, done
    );
endinterface

// File: rtl/song_sequencer.sv
// Song playback sequencer: walks a note ROM (one song per address quarter),
// sounds each pitch for its duration in beat ticks, inserts a silent gap,
// supports pause/resume and pulses done at end of song.
// Optional build macro: SONG_SEQUENCER_LOOP_EN -- after the done pulse the
// same song restarts from index 0 instead of returning to idle.
module song_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int PITCH_W   = 5,
    parameter int DUR_W     = 6,
    parameter int GAP_TICKS = 1
) (
    input  logic clk,
    input  logic reset,
    song_sequencer_if.slave bus
);
    localparam int         IDX_W = ADDR_W - 2;
    localparam logic [3:0] GAP_L = 4'(GAP_TICKS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_ROM, S_LOAD, S_PLAY_NOTE, S_GAP, S_PAUSED, S_DONE
    } state_t;

    state_t             r_state, w_state_next;
    logic [1:0]         r_song, w_song_next;
    logic [IDX_W-1:0]   r_idx, w_idx_next;
    logic [DUR_W-1:0]   r_dur_cnt, w_dur_cnt_next;
    logic [3:0]         r_gap_cnt, w_gap_cnt_next;
    logic [PITCH_W-1:0] r_pitch, w_pitch_next;
    logic               r_from_gap, w_from_gap_next;     // PAUSED origin: 1 = GAP
    logic               r_pause_pend, w_pause_pend_next; // pause seen mid-fetch
    logic               w_note_valid;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_song       <= '0;
            r_idx        <= '0;
            r_dur_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_pitch      <= '0;
            r_from_gap   <= 1'b0;
            r_pause_pend <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_song       <= w_song_next;
            r_idx        <= w_idx_next;
            r_dur_cnt    <= w_dur_cnt_next;
            r_gap_cnt    <= w_gap_cnt_next;
            r_pitch      <= w_pitch_next;
            r_from_gap   <= w_from_gap_next;
            r_pause_pend <= w_pause_pend_next;
        end
    end

    // Next-state and counter logic; pause always beats play and beat_tick
    always_comb begin
        w_state_next      = r_state;
        w_song_next       = r_song;
        w_idx_next        = r_idx;
        w_dur_cnt_next    = r_dur_cnt;
        w_gap_cnt_next    = r_gap_cnt;
        w_pitch_next      = r_pitch;
        w_from_gap_next   = r_from_gap;
        w_pause_pend_next = r_pause_pend;

        case (r_state)
            S_IDLE: begin
                if (bus.play && !bus.pause) begin
                    w_song_next  = bus.song_sel;
                    w_idx_next   = '0;
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.pause) w_pause_pend_next = 1'b1;
                w_state_next = S_WAIT_ROM;
            end
            S_WAIT_ROM: begin
                if (bus.pause) w_pause_pend_next = 1'b1;
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                if (bus.rom_dur == '0) begin
                    w_pause_pend_next = 1'b0;
                    w_state_next      = S_DONE;
                end else begin
                    if (bus.pause) w_pause_pend_next = 1'b1;
                    w_dur_cnt_next = bus.rom_dur;
                    w_pitch_next   = bus.rom_pitch;
                    w_state_next   = S_PLAY_NOTE;
                end
            end
            S_PLAY_NOTE: begin
                if (bus.pause || r_pause_pend) begin
                    w_pause_pend_next = 1'b0;
                    w_from_gap_next   = 1'b0;
                    w_state_next      = S_PAUSED;
                end else if (bus.beat_tick) begin
                    if (r_dur_cnt == DUR_W'(1)) begin
                        if (&r_idx) begin
                            // last slot of the quarter: never spill into the next song
                            w_state_next = S_DONE;
                        end else begin
                            w_idx_next = r_idx + IDX_W'(1);
                            if (GAP_L == 4'd0) begin
                                w_state_next = S_FETCH;
                            end else begin
                                w_gap_cnt_next = GAP_L;
                                w_state_next   = S_GAP;
                            end
                        end
                    end else begin
                        w_dur_cnt_next = r_dur_cnt - DUR_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (bus.pause) begin
                    w_from_gap_next = 1'b1;
                    w_state_next    = S_PAUSED;
                end else if (bus.beat_tick) begin
                    if (r_gap_cnt == 4'd1) w_state_next = S_FETCH;
                    else                   w_gap_cnt_next = r_gap_cnt - 4'd1;
                end
            end
            S_PAUSED: begin
                if (bus.play && !bus.pause)
                    w_state_next = r_from_gap ? S_GAP : S_PLAY_NOTE;
            end
            S_DONE: begin
                w_idx_next = '0;
`ifdef SONG_SEQUENCER_LOOP_EN
                w_state_next = S_FETCH;
`else
                w_state_next = S_IDLE;
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_note_valid   = (r_state == S_PLAY_NOTE);
    assign bus.note_valid = w_note_valid;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.rom_addr   = {r_song, r_idx};

    // Pitch is forced silent whenever no note is sounding
    generate
        for (genvar gi = 0; gi < PITCH_W; gi++) begin : g_pitch_gate
            assign bus.note_pitch[gi] = r_pitch[gi] & w_note_valid;
        end
    endgenerate
endmodule

// File: tb/tb_song_sequencer.sv
// Directed self-checking bench for song_sequencer with a registered-read ROM model.
module tb_song_sequencer;
    localparam int ADDR_W  = 8;
    localparam int PITCH_W = 5;
    localparam int DUR_W   = 6;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [PITCH_W-1:0] rom_p [0:255];
    logic [DUR_W-1:0]   rom_d [0:255];

    song_sequencer_if #(.ADDR_W(ADDR_W), .PITCH_W(PITCH_W), .DUR_W(DUR_W)) bus ();

    song_sequencer #(.ADDR_W(ADDR_W), .PITCH_W(PITCH_W), .DUR_W(DUR_W), .GAP_TICKS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ROM with one-cycle registered read
    always @(posedge clk) begin
        bus.rom_pitch <= rom_p[bus.rom_addr];
        bus.rom_dur   <= rom_d[bus.rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
            $display("check %s: observed=%0h expected=%0h ok", tag, obs, exp);
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic beat();
        bus.beat_tick = 1'b1;
        step();
        bus.beat_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
    endtask

    task automatic start(input logic [1:0] s);
        bus.song_sel = s;
        bus.play     = 1'b1;
        step();
        bus.play     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom_p[i] = '0;
            rom_d[i] = '0;
        end
        // song0: (3,2),(7,1),end
        rom_p[0] = 5'd3; rom_d[0] = 6'd2;
        rom_p[1] = 5'd7; rom_d[1] = 6'd1;
        // song1: (9,5),end
        rom_p[8'h40] = 5'd9; rom_d[8'h40] = 6'd5;
        // song2: (5,1),(6,1),end
        rom_p[8'h80] = 5'd5; rom_d[8'h80] = 6'd1;
        rom_p[8'h81] = 5'd6; rom_d[8'h81] = 6'd1;
        // song3: 64 one-beat notes, no end marker
        for (int i = 0; i < 64; i++) begin
            rom_p[192+i] = 5'((i % 31) + 1);
            rom_d[192+i] = 6'd1;
        end

        bus.beat_tick = 1'b0;
        bus.play      = 1'b0;
        bus.pause     = 1'b0;
        bus.song_sel  = 2'd0;

        // reset state
        do_reset();
        check("rst_valid", 32'(bus.note_valid), 0);
        check("rst_pitch", 32'(bus.note_pitch), 0);
        check("rst_busy",  32'(bus.busy), 0);
        check("rst_done",  32'(bus.done), 0);
        check("rst_addr",  32'(bus.rom_addr), 0);

        // song0 playback with one-tick gaps
        start(2'd0);
        check("s0_fetch0_addr", 32'(bus.rom_addr), 0);
        check("s0_fetch0_busy", 32'(bus.busy), 1);
        steps(3);
        check("s0_n0_valid", 32'(bus.note_valid), 1);
        check("s0_n0_pitch", 32'(bus.note_pitch), 3);
        beat();
        check("s0_n0_tick1_pitch", 32'(bus.note_pitch), 3);
        beat();
        check("s0_gap0_valid", 32'(bus.note_valid), 0);
        check("s0_gap0_pitch", 32'(bus.note_pitch), 0);
        beat();
        check("s0_fetch1_addr", 32'(bus.rom_addr), 1);
        steps(3);
        check("s0_n1_pitch", 32'(bus.note_pitch), 7);
        beat();
        check("s0_gap1_pitch", 32'(bus.note_pitch), 0);
        beat();
        check("s0_fetch2_addr", 32'(bus.rom_addr), 2);
        check("s0_fetch2_done", 32'(bus.done), 0);
        steps(3);
        check("s0_done_pulse", 32'(bus.done), 1);
        check("s0_done_valid", 32'(bus.note_valid), 0);
        step();
        check("s0_done_once", 32'(bus.done), 0);
`ifdef SONG_SEQUENCER_LOOP_EN
        check("s0_loop_busy", 32'(bus.busy), 1);
        check("s0_loop_addr", 32'(bus.rom_addr), 0);
        steps(3);
        check("s0_loop_pitch", 32'(bus.note_pitch), 3);
`else
        check("s0_idle_busy", 32'(bus.busy), 0);
        check("s0_idle_addr", 32'(bus.rom_addr), 0);
`endif

        // song select latched on start only
        do_reset();
        start(2'd2);
        check("s2_addr0", 32'(bus.rom_addr), 8'h80);
        bus.song_sel = 2'd1;
        steps(3);
        check("s2_pitch0", 32'(bus.note_pitch), 5);
        check("s2_addr_hold", 32'(bus.rom_addr), 8'h80);
        beat();
        check("s2_addr1", 32'(bus.rom_addr), 8'h81);

        // pause at dur_cnt=3 of a 5-tick note, ticks ignored while paused
        do_reset();
        start(2'd1);
        steps(3);
        check("p_pitch", 32'(bus.note_pitch), 9);
        beat();
        beat();
        bus.pause = 1'b1;
        step();
        bus.pause = 1'b0;
        check("p_paused_valid", 32'(bus.note_valid), 0);
        check("p_paused_pitch", 32'(bus.note_pitch), 0);
        check("p_paused_busy",  32'(bus.busy), 1);
        for (int i = 0; i < 4; i++) beat();
        check("p_paused_after_ticks", 32'(bus.note_valid), 0);
        bus.play = 1'b1;
        step();
        bus.play = 1'b0;
        check("p_resume_pitch", 32'(bus.note_pitch), 9);
        beat();
        beat();
        check("p_resume_2ticks", 32'(bus.note_valid), 1);
        beat();
        check("p_resume_3ticks", 32'(bus.note_valid), 0);
        check("p_next_addr", 32'(bus.rom_addr), 8'h41);

        // pause, play and beat_tick together: pause wins, tick not counted
        do_reset();
        start(2'd1);
        steps(3);
        beat();
        bus.pause = 1'b1; bus.play = 1'b1; bus.beat_tick = 1'b1;
        step();
        bus.pause = 1'b0; bus.play = 1'b0; bus.beat_tick = 1'b0;
        check("sim_paused", 32'(bus.note_valid), 0);
        bus.play = 1'b1;
        step();
        bus.play = 1'b0;
        beat(); beat(); beat();
        check("sim_dur_kept", 32'(bus.note_valid), 1);
        beat();
        check("sim_dur_end", 32'(bus.note_valid), 0);

        // full 64-entry song without end marker
        do_reset();
        start(2'd3);
        for (int i = 0; i < 64; i++) begin
            check($sformatf("full_addr%0d", i), 32'(bus.rom_addr), 32'(192 + i));
            steps(3);
            check($sformatf("full_pitch%0d", i), 32'(bus.note_pitch), 32'((i % 31) + 1));
            beat();
            if (i < 63) beat();
        end
        check("full_done", 32'(bus.done), 1);
        check("full_addr_last", 32'(bus.rom_addr), 8'hFF);
        step();
        check("full_done_once", 32'(bus.done), 0);
`ifndef SONG_SEQUENCER_LOOP_EN
        check("full_idle_busy", 32'(bus.busy), 0);
`endif

        // reset mid-note, then restart at idx 0
        do_reset();
        start(2'd1);
        steps(3);
        beat();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mr_valid", 32'(bus.note_valid), 0);
        check("mr_pitch", 32'(bus.note_pitch), 0);
        check("mr_busy",  32'(bus.busy), 0);
        check("mr_done",  32'(bus.done), 0);
        check("mr_addr",  32'(bus.rom_addr), 0);
        start(2'd0);
        check("mr_restart_addr", 32'(bus.rom_addr), 0);
        steps(3);
        check("mr_restart_pitch", 32'(bus.note_pitch), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
